// File: rtl/ex_mem_stage_if.sv
// ID/EX-to-EX/MEM bundle: decoded operands and controls in, latched EX/MEM fields out.
// The stage itself takes the slave side; the upstream ID/EX side takes the master side.
interface ex_mem_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
);
    logic [1:0]        Wb1;
    logic [2:0]        Mem1;
    logic              RegDst;
    logic [2:0]        ALUOp;
    logic              ALUSrc;
    logic [DATA_W-1:0] tAdd;
    logic [DATA_W-1:0] tALU;
    logic [DATA_W-1:0] tMux32;
    logic [DATA_W-1:0] tACsl;
    logic [REG_W-1:0]  tMux5_1;
    logic [REG_W-1:0]  tMux5_2;
    logic              jump_in;
    logic [25:0]       insad_in;
    logic              flush;

    logic              stall;
    logic [1:0]        Wb2;
    logic [2:0]        Mem2;
    logic [DATA_W-1:0] aluRes;
    logic              zero;
    logic [DATA_W-1:0] brTarget;
    logic [DATA_W-1:0] wrData;
    logic [REG_W-1:0]  wrReg;
    logic              jump_out;
    logic [DATA_W-1:0] jumpAddr;

    modport master (
        output Wb1, Mem1, RegDst, ALUOp, ALUSrc, tAdd, tALU, tMux32, tACsl,
               tMux5_1, tMux5_2, jump_in, insad_in, flush,
        input  stall, Wb2, Mem2, aluRes, zero, brTarget, wrData, wrReg,
               jump_out, jumpAddr
    );

    modport slave (
        input  Wb1, Mem1, RegDst, ALUOp, ALUSrc, tAdd, tALU, tMux32, tACsl,
               tMux5_1, tMux5_2, jump_in, insad_in, flush,
        output stall, Wb2, Mem2, aluRes, zero, brTarget, wrData, wrReg,
               jump_out, jumpAddr
    );
endinterface

// File: rtl/ex_mem_stage.sv
// Execute stage with EX/MEM latch. Single-cycle ALU ops plus a shift-add MUL
// that holds the upstream pipeline via stall until its result is latched.
module ex_mem_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic           clkEXMEM,
    input  logic           rstEXMEM,
    ex_mem_stage_if.slave  bus
);
    localparam int              CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [2:0]      OP_MUL   = 3'b101;

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DONE} state_t;

    state_t state_reg, state_next;

    logic [DATA_W-1:0] operand_b, alu_result, br_target, jump_addr;
    logic [REG_W-1:0]  dest;

    logic [DATA_W-1:0] mcand_reg, mplier_reg, acc_reg, addend, acc_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic [1:0]        wb_cap_reg;
    logic [2:0]        mem_cap_reg;
    logic [REG_W-1:0]  dest_cap_reg;
    logic              jump_cap_reg;
    logic [DATA_W-1:0] br_cap_reg, wr_data_cap_reg, jaddr_cap_reg;

    logic [1:0]        wb_reg;
    logic [2:0]        mem_reg;
    logic [DATA_W-1:0] alu_res_reg, br_target_reg, wr_data_reg, jump_addr_reg;
    logic              zero_reg, jump_reg;
    logic [REG_W-1:0]  wr_reg_reg;

    logic stall, issue, step, finish, load_alu;

    assign operand_b = bus.ALUSrc ? bus.tACsl : bus.tMux32;
    assign dest      = bus.RegDst ? bus.tMux5_2 : bus.tMux5_1;
    assign br_target = bus.tAdd + (bus.tACsl << 2);
    assign jump_addr = DATA_W'({bus.tAdd[DATA_W-1 -: 4], bus.insad_in, 2'b00});

    always_comb begin
        alu_result = '0;
        case (bus.ALUOp)
            3'b000:  alu_result = bus.tALU + operand_b;
            3'b001:  alu_result = bus.tALU - operand_b;
            3'b010:  alu_result = bus.tALU & operand_b;
            3'b011:  alu_result = bus.tALU | operand_b;
            3'b100:  alu_result = {{(DATA_W-1){1'b0}}, ($signed(bus.tALU) < $signed(operand_b))};
            3'b110:  alu_result = ~(bus.tALU | operand_b);
            3'b111:  alu_result = operand_b;
            default: alu_result = '0;
        endcase
    end

    // One partial product per step: the shifted multiplicand gated by the current multiplier LSB.
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_addend
        assign addend[gi] = mcand_reg[gi] & mplier_reg[0];
    end
    assign acc_next = acc_reg + addend;

    always_ff @(posedge clkEXMEM or posedge rstEXMEM) begin
        if (rstEXMEM) state_reg <= ST_IDLE;
        else          state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (bus.flush) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: if (bus.ALUOp == OP_MUL) state_next = ST_MUL;
                ST_MUL:  if (cnt_reg == CNT_LAST) state_next = ST_DONE;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        stall    = 1'b0;
        issue    = 1'b0;
        step     = 1'b0;
        finish   = 1'b0;
        load_alu = 1'b0;
        if (!bus.flush) begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.ALUOp == OP_MUL) begin
                        stall = 1'b1;
                        issue = 1'b1;
                    end else begin
                        load_alu = 1'b1;
                    end
                end
                ST_MUL: begin
                    stall  = 1'b1;
                    step   = 1'b1;
                    finish = (cnt_reg == CNT_LAST);
                end
                default: ;
            endcase
        end
    end

    // Operands and EX/MEM fields of a MUL are frozen at issue; later input changes are ignored.
    always_ff @(posedge clkEXMEM or posedge rstEXMEM) begin
        if (rstEXMEM) begin
            mcand_reg       <= '0;
            mplier_reg      <= '0;
            acc_reg         <= '0;
            cnt_reg         <= '0;
            wb_cap_reg      <= '0;
            mem_cap_reg     <= '0;
            dest_cap_reg    <= '0;
            jump_cap_reg    <= 1'b0;
            br_cap_reg      <= '0;
            wr_data_cap_reg <= '0;
            jaddr_cap_reg   <= '0;
        end else if (issue) begin
            mcand_reg       <= bus.tALU;
            mplier_reg      <= operand_b;
            acc_reg         <= '0;
            cnt_reg         <= '0;
            wb_cap_reg      <= bus.Wb1;
            mem_cap_reg     <= bus.Mem1;
            dest_cap_reg    <= dest;
            jump_cap_reg    <= bus.jump_in;
            br_cap_reg      <= br_target;
            wr_data_cap_reg <= bus.tMux32;
            jaddr_cap_reg   <= jump_addr;
        end else if (step) begin
            acc_reg    <= acc_next;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            cnt_reg    <= cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clkEXMEM or posedge rstEXMEM) begin
        if (rstEXMEM) begin
            wb_reg        <= '0;
            mem_reg       <= '0;
            alu_res_reg   <= '0;
            zero_reg      <= 1'b0;
            br_target_reg <= '0;
            wr_data_reg   <= '0;
            wr_reg_reg    <= '0;
            jump_reg      <= 1'b0;
            jump_addr_reg <= '0;
        end else if (load_alu) begin
            wb_reg        <= bus.Wb1;
            mem_reg       <= bus.Mem1;
            alu_res_reg   <= alu_result;
            zero_reg      <= (alu_result == '0);
            br_target_reg <= br_target;
            wr_data_reg   <= bus.tMux32;
            wr_reg_reg    <= dest;
            jump_reg      <= bus.jump_in;
            jump_addr_reg <= jump_addr;
        end else if (finish) begin
            wb_reg        <= wb_cap_reg;
            mem_reg       <= mem_cap_reg;
            alu_res_reg   <= acc_next;
            zero_reg      <= (acc_next == '0);
            br_target_reg <= br_cap_reg;
            wr_data_reg   <= wr_data_cap_reg;
            wr_reg_reg    <= dest_cap_reg;
            jump_reg      <= jump_cap_reg;
            jump_addr_reg <= jaddr_cap_reg;
        end else begin
            wb_reg   <= '0;
            mem_reg  <= '0;
            jump_reg <= 1'b0;
        end
    end

    assign bus.stall    = stall;
    assign bus.Wb2      = wb_reg;
    assign bus.Mem2     = mem_reg;
    assign bus.aluRes   = alu_res_reg;
    assign bus.zero     = zero_reg;
    assign bus.brTarget = br_target_reg;
    assign bus.wrData   = wr_data_reg;
    assign bus.wrReg    = wr_reg_reg;
    assign bus.jump_out = jump_reg;
    assign bus.jumpAddr = jump_addr_reg;
endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: table of single-cycle ALU vectors, then
// hand sequences for MUL latency, flush, and asynchronous reset.
module tb_ex_mem_stage;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    ex_mem_stage_if #(.DATA_W(32), .REG_W(5)) bus();

    ex_mem_stage #(.DATA_W(32), .REG_W(5)) dut (
        .clkEXMEM (clk),
        .rstEXMEM (rst),
        .bus      (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [2:0]  op;
        logic        src;
        logic        dst;
        logic [31:0] a;
        logic [31:0] rt;
        logic [31:0] imm;
        logic [31:0] pc4;
        logic [4:0]  rt_f;
        logic [4:0]  rd_f;
        logic [1:0]  wb;
        logic [2:0]  mem;
        logic        jmp;
        logic [25:0] idx;
        logic [31:0] exp_res;
        logic        exp_zero;
        logic [31:0] exp_br;
        logic [4:0]  exp_reg;
        logic [31:0] exp_jaddr;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input logic fl);
        bus.ALUOp    = v.op;
        bus.ALUSrc   = v.src;
        bus.RegDst   = v.dst;
        bus.tALU     = v.a;
        bus.tMux32   = v.rt;
        bus.tACsl    = v.imm;
        bus.tAdd     = v.pc4;
        bus.tMux5_1  = v.rt_f;
        bus.tMux5_2  = v.rd_f;
        bus.Wb1      = v.wb;
        bus.Mem1     = v.mem;
        bus.jump_in  = v.jmp;
        bus.insad_in = v.idx;
        bus.flush    = fl;
    endtask

    task automatic set_mul(input logic [31:0] a, input logic [31:0] b);
        bus.ALUOp   = 3'b101;
        bus.ALUSrc  = 1'b0;
        bus.RegDst  = 1'b0;
        bus.tALU    = a;
        bus.tMux32  = b;
        bus.tMux5_1 = 5'd9;
        bus.Wb1     = 2'b11;
        bus.Mem1    = 3'b100;
        bus.jump_in = 1'b0;
        bus.flush   = 1'b0;
    endtask

    initial begin
        int          n;
        logic        ok;
        logic        seen_res;
        logic        seen_stall;

        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;

        //         op   src  dst  a             rt            imm           pc4           rt  rd   wb     mem     j     idx           res           z     br            reg   jaddr
        vecs[0]  = '{3'd0, 1'b1, 1'b0, 32'd5,        32'h1234,     32'hFFFFFFFD, 32'h100,      5'd7, 5'd3,  2'b10, 3'b001, 1'b1, 26'h40,      32'd2,        1'b0, 32'hF4,       5'd7,  32'h100};
        vecs[1]  = '{3'd1, 1'b0, 1'b1, 32'd9,        32'd9,        32'd4,        32'h100,      5'd1, 5'd12, 2'b01, 3'b010, 1'b0, 26'h0,       32'd0,        1'b1, 32'h110,      5'd12, 32'h0};
        vecs[2]  = '{3'd2, 1'b0, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0,        32'hA0000000, 5'd4, 5'd5,  2'b11, 3'b100, 1'b1, 26'h3FFFFFF, 32'hF000F000, 1'b0, 32'hA0000000, 5'd4,  32'hAFFFFFFC};
        vecs[3]  = '{3'd3, 1'b1, 1'b1, 32'hF,        32'h1234,     32'hF0,       32'd4,        5'd2, 5'd30, 2'b00, 3'b000, 1'b0, 26'h0,       32'hFF,       1'b0, 32'h3C4,      5'd30, 32'h0};
        vecs[4]  = '{3'd4, 1'b0, 1'b0, 32'h80000000, 32'd1,        32'd0,        32'h200,      5'd8, 5'd9,  2'b01, 3'b001, 1'b0, 26'h0,       32'd1,        1'b0, 32'h200,      5'd8,  32'h0};
        vecs[5]  = '{3'd4, 1'b0, 1'b1, 32'd1,        32'h80000000, 32'd0,        32'h200,      5'd8, 5'd9,  2'b10, 3'b010, 1'b0, 26'h0,       32'd0,        1'b1, 32'h200,      5'd9,  32'h0};
        vecs[6]  = '{3'd0, 1'b0, 1'b0, 32'h7FFFFFFF, 32'd1,        32'd0,        32'h200,      5'd31,5'd0,  2'b11, 3'b011, 1'b0, 26'h0,       32'h80000000, 1'b0, 32'h200,      5'd31, 32'h0};
        vecs[7]  = '{3'd6, 1'b0, 1'b0, 32'd0,        32'd0,        32'd0,        32'h200,      5'd1, 5'd2,  2'b00, 3'b101, 1'b0, 26'h0,       32'hFFFFFFFF, 1'b0, 32'h200,      5'd1,  32'h0};
        vecs[8]  = '{3'd7, 1'b1, 1'b1, 32'hDEAD,     32'd0,        32'h12345678, 32'd0,        5'd0, 5'd17, 2'b01, 3'b110, 1'b1, 26'h1,       32'h12345678, 1'b0, 32'h48D159E0, 5'd17, 32'h4};
        vecs[9]  = '{3'd1, 1'b0, 1'b0, 32'd0,        32'd1,        32'd0,        32'h200,      5'd3, 5'd4,  2'b10, 3'b111, 1'b0, 26'h0,       32'hFFFFFFFF, 1'b0, 32'h200,      5'd3,  32'h0};
        vecs[10] = '{3'd7, 1'b0, 1'b0, 32'd5,        32'd0,        32'h10,       32'h40,       5'd6, 5'd7,  2'b01, 3'b000, 1'b0, 26'h0,       32'd0,        1'b1, 32'h80,       5'd6,  32'h0};

        apply(vecs[0], 1'b0);
        #1 rst = 1'b1;
        #2;
        check("reset_aluRes", bus.aluRes, 0);
        check("reset_wb2", bus.Wb2, 0);
        check("reset_stall", bus.stall, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Single-cycle ALU vectors
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            apply(vecs[i], 1'b0);
            #1 check("alu_stall", bus.stall, 0);
            @(posedge clk);
            #1;
            check("aluRes",   bus.aluRes,   vecs[i].exp_res);
            check("zero",     bus.zero,     vecs[i].exp_zero);
            check("brTarget", bus.brTarget, vecs[i].exp_br);
            check("wrReg",    bus.wrReg,    vecs[i].exp_reg);
            check("wrData",   bus.wrData,   vecs[i].rt);
            check("Wb2",      bus.Wb2,      vecs[i].wb);
            check("Mem2",     bus.Mem2,     vecs[i].mem);
            check("jump_out", bus.jump_out, vecs[i].jmp);
            check("jumpAddr", bus.jumpAddr, vecs[i].exp_jaddr);
            $display("vec %0d op=%0d aluRes=%h zero=%0d brTarget=%h wrReg=%0d",
                     i, vecs[i].op, bus.aluRes, bus.zero, bus.brTarget, bus.wrReg);
        end

        // Flush while idle: bubble, data fields hold
        @(negedge clk);
        apply(vecs[2], 1'b0);
        @(negedge clk);
        apply(vecs[0], 1'b1);
        #1 check("flush_idle_stall", bus.stall, 0);
        @(posedge clk);
        #1;
        check("flush_idle_wb2", bus.Wb2, 0);
        check("flush_idle_mem2", bus.Mem2, 0);
        check("flush_idle_jump", bus.jump_out, 0);
        check("flush_idle_hold_res", bus.aluRes, 32'hF000F000);
        check("flush_idle_hold_reg", bus.wrReg, 4);
        $display("flush in IDLE: Wb2=%0d aluRes=%h", bus.Wb2, bus.aluRes);

        // MUL 0xFFFFFFFF * 3
        @(negedge clk);
        set_mul(32'hFFFFFFFF, 32'd3);
        #1;
        n  = 0;
        ok = 1'b1;
        for (int k = 0; k < 60; k++) begin
            if (!bus.stall) break;
            @(posedge clk);
            #1;
            n++;
            if (n < 33 && (bus.Wb2 != 2'b00 || bus.Mem2 != 3'b000)) ok = 1'b0;
            if (n == 1) begin
                bus.tALU   = 32'd0;
                bus.tMux32 = 32'd0;
            end
            @(negedge clk);
            #1;
        end
        check("mul_stall_cycles", n, 33);
        check("mul_bubbles", ok, 1);
        check("mul_aluRes", bus.aluRes, 32'hFFFFFFFD);
        check("mul_zero", bus.zero, 0);
        check("mul_wb2", bus.Wb2, 2'b11);
        check("mul_mem2", bus.Mem2, 3'b100);
        check("mul_wrReg", bus.wrReg, 9);
        $display("mul done after %0d stall cycles: aluRes=%h", n, bus.aluRes);
        @(posedge clk);
        #1;
        check("mul_after_wb2", bus.Wb2, 0);
        check("mul_after_mem2", bus.Mem2, 0);
        check("mul_after_hold", bus.aluRes, 32'hFFFFFFFD);
        @(negedge clk);
        apply(vecs[7], 1'b0);
        #1 check("mul_after_stall", bus.stall, 0);

        // Flush a MUL at cnt=10
        @(negedge clk);
        set_mul(32'd7, 32'd6);
        for (int k = 0; k < 11; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
        #1 check("flushmul_stall_before", bus.stall, 1);
        bus.flush = 1'b1;
        #1 check("flushmul_stall", bus.stall, 0);
        @(posedge clk);
        #1;
        check("flushmul_wb2", bus.Wb2, 0);
        check("flushmul_mem2", bus.Mem2, 0);
        @(negedge clk);
        bus.flush  = 1'b0;
        bus.ALUOp  = 3'b111;
        bus.ALUSrc = 1'b0;
        bus.tMux32 = 32'h55;
        bus.Wb1    = 2'b10;
        #1 check("flushmul_idle_stall", bus.stall, 0);
        seen_res   = 1'b0;
        seen_stall = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.aluRes == 32'd42) seen_res = 1'b1;
            if (bus.stall) seen_stall = 1'b1;
        end
        check("flushmul_no_result", seen_res, 0);
        check("flushmul_no_stall", seen_stall, 0);
        check("flushmul_next_op", bus.aluRes, 32'h55);
        $display("flush mid-MUL: aluRes=%h Wb2=%0d", bus.aluRes, bus.Wb2);

        // Asynchronous reset mid-cycle aborts an in-flight MUL
        @(negedge clk);
        set_mul(32'd7, 32'd6);
        repeat (5) @(posedge clk);
        @(negedge clk);
        apply(vecs[6], 1'b0);
        #2 rst = 1'b1;
        #1;
        check("rst_aluRes", bus.aluRes, 0);
        check("rst_brTarget", bus.brTarget, 0);
        check("rst_wrData", bus.wrData, 0);
        check("rst_wrReg", bus.wrReg, 0);
        check("rst_wb2", bus.Wb2, 0);
        check("rst_mem2", bus.Mem2, 0);
        check("rst_jump", bus.jump_out, 0);
        check("rst_jumpAddr", bus.jumpAddr, 0);
        check("rst_zero", bus.zero, 0);
        check("rst_stall", bus.stall, 0);
        $display("async reset: aluRes=%h stall=%0d", bus.aluRes, bus.stall);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_add", bus.aluRes, 32'h80000000);
        check("post_rst_wb2", bus.Wb2, 2'b11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
